// File: rtl/j1_dbus_uart.sv
// rtl/j1_dbus_uart.sv - J1 data-bus UART responder with TX FIFO and RX holding register
module j1_dbus_uart #(
  parameter logic [15:0] BASE        = 16'h7FFC,
  parameter int          TX_DEPTH    = 16,
  parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] dbus_adr,
  input  logic        dbus_re,
  input  logic        dbus_we,
  input  logic [15:0] dbus_dat_o,
  output logic [15:0] dbus_dat_i,
  input  logic        uart_rxd,
  output logic        uart_txd,
  output logic        irq
);
  localparam int AW = $clog2(TX_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(TX_DEPTH);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_e;

  logic        hit, wr_en, rd_en, wr_data, wr_stat, wr_div, wr_ien, rd_data;
  logic [1:0]  sel;
  logic [7:0]  fifo_q [TX_DEPTH];
  logic [AW:0] wptr_q, rptr_q, fifo_cnt;
  logic        fifo_full, fifo_empty, push, tx_pop, tx_empty;

  tx_state_e   tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic        txd_q, txd_d;

  rx_state_e   rx_state_q, rx_state_d;
  logic [1:0]  rx_sync_q;
  logic        rxd_s, rx_done, rx_ferr;
  logic [15:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d, rx_half;
  logic [16:0] rx_div_p1;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d;

  logic [15:0] div_q, div_d, dat_q, dat_d, status, rd_mux;
  logic [1:0]  ien_q, ien_d;
  logic [7:0]  rx_byte_q, rx_byte_d;
  logic        rx_valid_q, rx_valid_d, rx_ovr_q, rx_ovr_d, tx_ovf_q, tx_ovf_d;
  logic        frame_err_q, frame_err_d, irq_q, irq_d;

  assign hit     = dbus_adr[15:2] == BASE[15:2];
  assign sel     = dbus_adr[1:0];
  assign wr_en   = dbus_we & hit;
  assign rd_en   = dbus_re & hit & ~dbus_we;
  assign wr_data = wr_en && sel == 2'd0;
  assign wr_stat = wr_en && sel == 2'd1;
  assign wr_div  = wr_en && sel == 2'd2;
  assign wr_ien  = wr_en && sel == 2'd3;
  assign rd_data = rd_en && sel == 2'd0;

  assign fifo_cnt   = wptr_q - rptr_q;
  assign fifo_full  = fifo_cnt == FULL_CNT;
  assign fifo_empty = wptr_q == rptr_q;
  assign push       = wr_data & ~fifo_full;
  assign tx_empty   = fifo_empty && tx_state_q == TX_IDLE;

  always_ff @(posedge clk) begin
    if (push) fifo_q[wptr_q[AW-1:0]] <= dbus_dat_o[7:0];
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + 16'd1;
    tx_div_d   = tx_div_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    txd_d      = txd_q;
    tx_pop     = 1'b0;
    unique case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d = '0;
        tx_pop   = ~fifo_empty;
      end
      TX_START: if (tx_cnt_q == tx_div_q) begin
        tx_cnt_d   = '0;
        tx_state_d = TX_DATA;
        tx_bit_d   = '0;
        txd_d      = tx_shift_q[0];
        tx_shift_d = tx_shift_q >> 1;
      end
      TX_DATA: if (tx_cnt_q == tx_div_q) begin
        tx_cnt_d = '0;
        if (tx_bit_q == 3'd7) begin
          tx_state_d = TX_STOP;
          txd_d      = 1'b1;
        end else begin
          tx_bit_d   = tx_bit_q + 3'd1;
          txd_d      = tx_shift_q[0];
          tx_shift_d = tx_shift_q >> 1;
        end
      end
      TX_STOP: if (tx_cnt_q == tx_div_q) begin
        tx_cnt_d = '0;
        if (fifo_empty) tx_state_d = TX_IDLE;
        else            tx_pop     = 1'b1;
      end
    endcase
    // Popping always starts a new frame, from IDLE or straight out of STOP.
    if (tx_pop) begin
      tx_state_d = TX_START;
      tx_shift_d = fifo_q[rptr_q[AW-1:0]];
      tx_div_d   = div_q;
      tx_cnt_d   = '0;
      txd_d      = 1'b0;
    end
  end

  assign rxd_s     = rx_sync_q[1];
  assign rx_div_p1 = {1'b0, rx_div_q} + 17'd1;
  assign rx_half   = rx_div_p1[16:1];

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 16'd1;
    rx_div_d   = rx_div_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_done    = 1'b0;
    rx_ferr    = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        // The detecting cycle already sees the line low, so it counts as cycle 1.
        rx_cnt_d = 16'd1;
        if (!rxd_s) begin
          rx_state_d = RX_START;
          rx_div_d   = div_q;
        end
      end
      RX_START: if (rx_cnt_q == rx_half) begin
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_state_d = rxd_s ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_cnt_q == rx_div_q) begin
        rx_cnt_d   = '0;
        rx_shift_d = {rxd_s, rx_shift_q[7:1]};
        if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        else                  rx_bit_d   = rx_bit_q + 3'd1;
      end
      RX_STOP: if (rx_cnt_q == rx_div_q) begin
        rx_cnt_d   = '0;
        rx_done    = rxd_s;
        rx_ferr    = ~rxd_s;
        rx_state_d = rxd_s ? RX_IDLE : RX_BREAK;
      end
      RX_BREAK: if (rxd_s) rx_state_d = RX_IDLE;
      default: rx_state_d = RX_IDLE;
    endcase
  end

  assign status = {10'h0, frame_err_q, tx_ovf_q, rx_ovr_q, tx_empty, fifo_full, rx_valid_q};

  always_comb begin
    unique case (sel)
      2'd0: rd_mux = {8'h0, rx_byte_q};
      2'd1: rd_mux = status;
      2'd2: rd_mux = div_q;
      2'd3: rd_mux = {14'h0, ien_q};
    endcase
    div_d       = wr_div ? ((dbus_dat_o < 16'd3) ? 16'd3 : dbus_dat_o) : div_q;
    ien_d       = wr_ien ? dbus_dat_o[1:0] : ien_q;
    tx_ovf_d    = (tx_ovf_q & ~(wr_stat & dbus_dat_o[4])) | (wr_data & fifo_full);
    rx_ovr_d    = (rx_ovr_q & ~(wr_stat & dbus_dat_o[3])) | (rx_done & rx_valid_q & ~rd_data);
    frame_err_d = (frame_err_q & ~(wr_stat & dbus_dat_o[5])) | rx_ferr;
    rx_valid_d  = rx_done | (rx_valid_q & ~rd_data);
    rx_byte_d   = rx_done ? rx_shift_q : rx_byte_q;
    irq_d       = (rx_valid_q & ien_q[0]) | (tx_empty & ien_q[1]);
    dat_d       = dat_q;
    if (dbus_re) dat_d = rd_en ? rd_mux : 16'h0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q <= '0;  rptr_q <= '0;
      tx_state_q <= TX_IDLE;  tx_cnt_q <= '0;  tx_div_q <= '0;
      tx_bit_q <= '0;  tx_shift_q <= '0;  txd_q <= 1'b1;
      rx_state_q <= RX_IDLE;  rx_sync_q <= 2'b11;  rx_cnt_q <= '0;
      rx_div_q <= '0;  rx_bit_q <= '0;  rx_shift_q <= '0;
      div_q <= DEFAULT_DIV;  ien_q <= '0;  dat_q <= '0;  rx_byte_q <= '0;
      rx_valid_q <= 1'b0;  rx_ovr_q <= 1'b0;  tx_ovf_q <= 1'b0;
      frame_err_q <= 1'b0;  irq_q <= 1'b0;
    end else begin
      if (push)   wptr_q <= wptr_q + 1'b1;
      if (tx_pop) rptr_q <= rptr_q + 1'b1;
      tx_state_q <= tx_state_d;  tx_cnt_q <= tx_cnt_d;  tx_div_q <= tx_div_d;
      tx_bit_q <= tx_bit_d;  tx_shift_q <= tx_shift_d;  txd_q <= txd_d;
      rx_state_q <= rx_state_d;  rx_sync_q <= {rx_sync_q[0], uart_rxd};
      rx_cnt_q <= rx_cnt_d;  rx_div_q <= rx_div_d;
      rx_bit_q <= rx_bit_d;  rx_shift_q <= rx_shift_d;
      div_q <= div_d;  ien_q <= ien_d;  dat_q <= dat_d;  rx_byte_q <= rx_byte_d;
      rx_valid_q <= rx_valid_d;  rx_ovr_q <= rx_ovr_d;  tx_ovf_q <= tx_ovf_d;
      frame_err_q <= frame_err_d;  irq_q <= irq_d;
    end
  end

  assign uart_txd   = txd_q;
  assign irq        = irq_q;
  assign dbus_dat_i = dat_q;
endmodule

// File: tb/tb_j1_dbus_uart.sv
// tb/tb_j1_dbus_uart.sv - directed self-checking bench for j1_dbus_uart
module tb_j1_dbus_uart;
  localparam logic [15:0] A_DATA = 16'h7FFC;
  localparam logic [15:0] A_STAT = 16'h7FFD;
  localparam logic [15:0] A_DIV  = 16'h7FFE;
  localparam logic [15:0] A_IEN  = 16'h7FFF;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] adr = '0, wdat = '0, rdat;
  logic        re = 1'b0, we = 1'b0;
  logic        rxd_drv = 1'b1, loop_en = 1'b0;
  logic        rxd_w, txd, irq;
  int          n_chk = 0, n_err = 0;
  int          cyc = 0;

  int          fall_n = 0, fall_first = 0, fall_last = 0;
  logic        mon_en = 1'b0, txd_prev = 1'b1;

  assign rxd_w = loop_en ? txd : rxd_drv;

  j1_dbus_uart dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .dbus_adr   (adr),
    .dbus_re    (re),
    .dbus_we    (we),
    .dbus_dat_o (wdat),
    .dbus_dat_i (rdat),
    .uart_rxd   (rxd_w),
    .uart_txd   (txd),
    .irq        (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_en && txd_prev && !txd) begin
      if (fall_n == 0) fall_first = cyc;
      fall_last = cyc;
      fall_n++;
    end
    txd_prev = txd;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic bus_wr(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    adr = a; wdat = d; we = 1'b1;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic bus_rd(input logic [15:0] a, output logic [15:0] d);
    @(negedge clk);
    adr = a; re = 1'b1;
    @(negedge clk);
    re = 1'b0;
    d = rdat;
  endtask

  task automatic poll_status(input logic [15:0] mask, input int bound, output logic ok);
    logic [15:0] s;
    ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      bus_rd(A_STAT, s);
      if ((s & mask) != 16'h0) ok = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rxd_drv = f[i];
      repeat (3) @(negedge clk);
    end
    @(negedge clk);
    rxd_drv = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [15:0] d;
    logic        ok;
    logic [39:0] obs, exp40;
    logic [9:0]  frame;
    int          k, rise;

    repeat (3) @(negedge clk);
    check("rst_dat_i", rdat, 16'h0);
    check("rst_irq", irq, 1'b0);
    check("rst_txd", txd, 1'b1);
    reset_n = 1'b1;

    // Reset asserted mid-frame at the default divisor
    bus_wr(A_DATA, 16'h0000);
    repeat (50) @(negedge clk);
    check("midframe_txd_low", txd, 1'b0);
    #2 reset_n = 1'b0;
    #1 check("async_rst_txd", txd, 1'b1);
    @(negedge clk);
    reset_n = 1'b1;
    bus_rd(A_STAT, d);  check("rst_status", d, 16'h0004);
    bus_rd(A_DIV, d);   check("rst_divisor", d, 16'd433);

    // Divisor clamp, then exact A5 waveform at DIVISOR=3
    bus_wr(A_DIV, 16'd2);
    bus_rd(A_DIV, d);   check("div_clamp", d, 16'd3);
    bus_wr(A_DIV, 16'd3);
    bus_wr(A_DATA, 16'h00A5);
    frame = {1'b1, 8'hA5, 1'b0};
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      obs[j]   = txd;
      exp40[j] = frame[j/4];
    end
    check("tx_a5_wave", obs, exp40);
    @(negedge clk);
    check("tx_idle_after", txd, 1'b1);
    bus_rd(A_STAT, d);  check("status_after_a5", d, 16'h0004);

    // FIFO overflow and back-to-back frames
    mon_en = 1'b1;
    for (int i = 0; i < 18; i++) bus_wr(A_DATA, 16'h0000);
    bus_rd(A_STAT, d);  check("fifo_full_ovf", d, 16'h0012);
    bus_wr(A_STAT, 16'h0010);
    bus_rd(A_STAT, d);  check("ovf_cleared", d & 16'h0010, 16'h0000);
    poll_status(16'h0004, 600, ok);
    check("fifo_drained", ok, 1'b1);
    mon_en = 1'b0;
    check("frame_count", fall_n, 17);
    check("back_to_back_span", fall_last - fall_first, 640);

    // Loopback receive, read-clear, overrun
    loop_en = 1'b1;
    bus_wr(A_DATA, 16'h003C);
    poll_status(16'h0001, 100, ok);
    check("rx_valid_set", ok, 1'b1);
    bus_rd(A_DATA, d);  check("rx_data_3c", d, 16'h003C);
    bus_rd(A_STAT, d);  check("rx_valid_clr", d, 16'h0004);
    bus_wr(A_DATA, 16'h0011);
    bus_wr(A_DATA, 16'h0022);
    repeat (10) @(negedge clk);
    poll_status(16'h0004, 200, ok);
    check("two_bytes_sent", ok, 1'b1);
    repeat (10) @(negedge clk);
    bus_rd(A_STAT, d);  check("rx_overrun", d, 16'h000D);
    bus_rd(A_DATA, d);  check("rx_data_2nd", d, 16'h0022);

    // Glitch rejection, framing error, recovery
    loop_en = 1'b0;
    bus_wr(A_STAT, 16'h0038);
    bus_rd(A_STAT, d);  check("w1c_clear", d, 16'h0004);
    @(negedge clk); rxd_drv = 1'b0;
    @(negedge clk); rxd_drv = 1'b1;
    repeat (20) @(negedge clk);
    bus_rd(A_STAT, d);  check("glitch_ignored", d, 16'h0004);
    send_frame(8'hC3, 1'b0);
    repeat (10) @(negedge clk);
    bus_rd(A_STAT, d);  check("frame_err", d, 16'h0024);
    send_frame(8'h5A, 1'b1);
    repeat (10) @(negedge clk);
    bus_rd(A_STAT, d);  check("rx_after_ferr", d, 16'h0025);
    bus_rd(A_DATA, d);  check("rx_data_5a", d, 16'h005A);

    // TX-empty interrupt timing and out-of-range accesses
    bus_wr(A_IEN, 16'h0000);
    bus_wr(A_DATA, 16'h0055);
    k = cyc;
    bus_wr(A_IEN, 16'hFFFE);
    bus_rd(A_IEN, d);   check("ien_readback", d, 16'h0002);
    rise = -1;
    for (int i = 0; i < 100 && rise < 0; i++) begin
      @(negedge clk);
      if (irq) rise = cyc;
    end
    check("irq_rise_offset", rise - k, 42);
    bus_rd(A_IEN, d);   check("ien_nonzero", d, 16'h0002);
    bus_rd(16'h8000, d); check("miss_read_zero", d, 16'h0000);
    bus_wr(16'h8002, 16'h0005);
    bus_wr(16'h8000, 16'h0077);
    repeat (2) @(negedge clk);
    bus_rd(A_DIV, d);   check("miss_write_div", d, 16'd3);
    bus_rd(A_STAT, d);  check("miss_write_status", d, 16'h0024);
    check("irq_level", irq, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
